// File: rtl/cfg_int_add_pipe.sv
// cfg_int_add_pipe: 2-stage pipelined adder with a runtime-configurable lower-part-OR approximation.
// Define CFG_INT_ADD_ERR_STATS_EN to add the err_cnt / err_mag_acc error-statistics outputs.
module cfg_int_add_pipe #(
  parameter int BWOP = 32,
  parameter int NAB  = 16,
  parameter int CW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_apx_bits,
  output logic            cfg_err,
  input  logic            apx_ctl,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BWOP-1:0] c,
  output logic            ovf
`ifdef CFG_INT_ADD_ERR_STATS_EN
  ,
  output logic [31:0]     err_cnt,
  output logic [47:0]     err_mag_acc
`endif
);

  localparam int L = BWOP / 2;
  localparam logic [CW-1:0] NAB_C = CW'(NAB);

  // Low half: bits below k are OR-ed, bit k gets a[k-1]&b[k-1] as carry-in, rest is exact.
  // Returns {carry_out, low_sum}.
  function automatic logic [L:0] loa_low(input logic [L-1:0] x, input logic [L-1:0] y,
                                         input logic [CW-1:0] k);
    logic [L-1:0] m;
    logic [L-1:0] top;
    logic         cin;
    logic [L:0]   s;
    m   = ~({L{1'b1}} << k);
    top = m ^ (m >> 1);
    cin = |(x & y & top);
    s   = {1'b0, x & ~m} + {1'b0, y & ~m} + ({{L{1'b0}}, cin} << k);
    return {s[L], s[L-1:0] | ((x | y) & m)};
  endfunction

  function automatic logic ovf_chk(input logic sa, input logic sb, input logic sc);
    return (sa == sb) && (sc != sa);
  endfunction

  logic                 vld_p1, vld_p2;
  logic                 s2_load, cfg_ok;
  logic [CW-1:0]        apx_bits, k_in;
  logic [L:0]           low_res;
  logic [L-1:0]         lo_p1;
  logic                 cy_p1;
  logic signed [L-1:0]  a_hi_p1, b_hi_p1, hi_sum;
  logic [BWOP-1:0]      c_nxt;

  assign s2_load   = !vld_p2 || out_ready;
  assign in_ready  = !rst && (!vld_p1 || s2_load);
  assign out_valid = vld_p2;
  assign cfg_ok    = cfg_we && !vld_p1 && !vld_p2 && !in_valid;
  assign k_in      = apx_ctl ? apx_bits : '0;
  assign low_res   = loa_low(a[L-1:0], b[L-1:0], k_in);
  assign hi_sum    = a_hi_p1 + b_hi_p1 + $signed({{(L-1){1'b0}}, cy_p1});
  assign c_nxt     = {hi_sum, lo_p1};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      apx_bits <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (s2_load)  vld_p2 <= vld_p1;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) apx_bits <= (cfg_apx_bits > NAB_C) ? NAB_C : cfg_apx_bits;
    end
  end

  // Stage 1: approximate low half and its carry, upper halves passed through
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      lo_p1   <= low_res[L-1:0];
      cy_p1   <= low_res[L];
      a_hi_p1 <= $signed(a[BWOP-1:L]);
      b_hi_p1 <= $signed(b[BWOP-1:L]);
    end
  end

  // Stage 2: upper-half add with carry, sum and overflow registered
  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      ovf <= 1'b0;
    end else if (s2_load && vld_p1) begin
      c   <= c_nxt;
      ovf <= ovf_chk(a_hi_p1[L-1], b_hi_p1[L-1], c_nxt[BWOP-1]);
    end
  end

`ifdef CFG_INT_ADD_ERR_STATS_EN
  localparam int AW = ((BWOP > 48) ? BWOP : 48) + 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (&x) ? x : x + 32'd1;
  endfunction

  function automatic logic [47:0] sat_acc(input logic [47:0] acc, input logic [BWOP-1:0] d);
    logic [AW-1:0] s;
    s = AW'(acc) + AW'(d);
    return (s > AW'({48{1'b1}})) ? {48{1'b1}} : s[47:0];
  endfunction

  logic [L-1:0]    a_lo_p1, b_lo_p1;
  logic [BWOP-1:0] exact_p2, diff;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_lo_p1 <= a[L-1:0];
      b_lo_p1 <= b[L-1:0];
    end
    if (s2_load && vld_p1) exact_p2 <= {a_hi_p1, a_lo_p1} + {b_hi_p1, b_lo_p1};
  end

  assign diff = (exact_p2 >= c) ? exact_p2 - c : c - exact_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt     <= '0;
      err_mag_acc <= '0;
    end else if (vld_p2 && out_ready && (c != exact_p2)) begin
      err_cnt     <= sat_inc(err_cnt);
      err_mag_acc <= sat_acc(err_mag_acc, diff);
    end
  end
`endif

endmodule

// File: doc/cfg_int_add_pipe.md
Name: cfg_int_add_pipe

Overview:
- Parametrised, 2-stage pipelined integer adder; successor to the fixed-width unconfigurable adder.
- Supports a runtime-configurable lower-part-OR approximation (LOA) of the low bits.
- Adds a valid/ready handshake, a signed-overflow flag and a config port.
- Sits in int_ops_apx as the drop-in adder for approximate datapaths and accuracy-sweep benches.

Parameters:
- BWOP, 32, operand/result width in bits; even, 8..64.
- NAB, 16, maximum approximable LSBs; 0 < NAB <= BWOP/2.
- CW, 5, config width for the approx-bit count; must satisfy 2^CW > NAB.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_apx_bits  in  CW  requested number of approximate LSBs.
- cfg_err  out  1  one-cycle pulse: config write rejected.
- apx_ctl  in  1  1 = approximate mode, 0 = exact; sampled per transaction with the operands.
- in_valid  in  1  operands valid.
- in_ready  out  1  adder can accept operands.
- a  in  BWOP  operand A (two's complement).
- b  in  BWOP  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- c  out  BWOP  sum, modulo 2^BWOP.
- ovf  out  1  signed overflow of the produced sum.

Behaviour:
- Reset (rst=1 at clock edge), cleared next cycle:
  - out_valid=0, c=0, ovf=0, cfg_err=0.
  - Both stage-valid bits 0; in-flight data discarded.
  - apx_bits register = 0 (exact).
  - in_ready=0 during reset, 1 in the first cycle after it.
- Config:
  - Write accepted only when cfg_we=1 and both stages are empty and in_valid=0.
  - Accepted value = min(cfg_apx_bits, NAB); takes effect on the next accepted transaction.
  - Otherwise the write is ignored and cfg_err=1 for exactly one cycle.
- Approximation, with k = apx_bits when the transaction's apx_ctl=1, else 0:
  - c[k-1:0] = a[k-1:0] | b[k-1:0].
  - Carry into bit k = a[k-1] & b[k-1] (0 when k=0).
  - Bits k..BWOP-1 are an exact ripple sum.
  - k=0 gives bit-exact a+b.
- Pipeline, with L = BWOP/2:
  - Stage 1 registers the low L-bit result (approx + exact part), its carry-out, a/b upper halves and the apx flag.
  - Stage 2 adds the upper halves plus the carry and registers c and ovf.
  - ovf = (a[MSB]==b[MSB]) && (c[MSB]!=a[MSB]), computed on the produced (possibly approximate) c.
  - Latency: 2 cycles from input handshake (in_valid&&in_ready) to out_valid with out_ready held high.
  - Throughput: 1/cycle.
- Handshake:
  - s2_load = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_load.
  - out_valid = s2_valid.
  - c/ovf remain stable while out_valid=1 && out_ready=0.
  - No transaction is lost or duplicated under any out_ready pattern.
  - A simultaneous stage-1 drain and new input is allowed in the same cycle.
- Wrap-around: carry out of the MSB is dropped; no saturation.
- Reset mid-operation: all in-flight results dropped, no out_valid in the cycle after reset, config returns to exact.

Optional Feature:
- Macro: CFG_INT_ADD_ERR_STATS_EN.
- Defined: adds outputs err_cnt[31:0] and err_mag_acc[47:0].
  - Stage 2 also computes the exact sum.
  - On each output handshake where c != exact: err_cnt increments by 1, and err_mag_acc adds |exact - c| as an unsigned BWOP-bit difference.
  - Both counters saturate at all-ones; reset to 0 on rst.
  - Adds no latency.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Exact add (BWOP=32, apx_bits=0): a=0x00000005, b=0x00000003 -> c=0x00000008, ovf=0, out_valid exactly 2 cycles after the handshake.
- Overflow/wrap: a=0x7FFFFFFF, b=0x00000001 -> c=0x80000000, ovf=1. Then a=0xFFFFFFFF, b=0x00000001 -> c=0x00000000, ovf=0.
- Approx: cfg_apx_bits=4, apx_ctl=1, a=0x0000000F, b=0x00000001 -> c=0x0000000F. Same operands with apx_ctl=0 -> c=0x00000010. cfg_apx_bits=31 -> stored as 16.
- Backpressure: stream 8 back-to-back sums while out_ready toggles 1,0,0,1,... -> all 8 results in order, c held stable while stalled, in_ready=0 only when both stages are full and out_ready=0.
- Config/reset: cfg_we while the pipeline is non-empty -> cfg_err pulses 1 cycle and the old apx_bits is kept. Assert rst with 2 in flight -> no out_valid afterwards; apx_bits reads back as 0 (next sum exact).
- (CFG_INT_ADD_ERR_STATS_EN) apx_bits=4, three sums of 0x0F+0x01 -> err_cnt=3, err_mag_acc=3.
